bno08x_dual_sensor_scheduler: RTL and testbench

Time-multiplexes one shared BNO08X SPI controller and drum-trigger datapath between two BNO08X sensors (left/right stick). Watches both sensors' interrupt lines, grants the shared path to one sensor at a time with round-robin fairness, drives `sensor_select`, gates per-sensor chip selects, and steers the resulting drum triggers back to per-sensor outputs. Sits between the board pins and the drum system top level.

---
 rtl/bno08x_dual_sensor_scheduler_pkg.sv | 25 ++
 rtl/bno08x_dual_sensor_scheduler_sync_2ff.sv | 29 ++
 rtl/bno08x_dual_sensor_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bno08x_dual_sensor_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bno08x_dual_sensor_scheduler_pkg.sv
// Shared definitions for the dual BNO08X sensor scheduler.
//   sched_state_t      : scheduler FSM states
//   DRUM_NONE          : drum code meaning "no trigger"
//   DEF_*              : default parameter values for the top level
//   pick_winner()      : round-robin arbitration between the two sensors
package bno08x_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

    localparam logic [3:0] DRUM_NONE          = 4'd8;
    localparam int         DEF_SETTLE_CYCLES  = 3;
    localparam int         DEF_TIMEOUT_CYCLES = 30000;

    // With both sensors pending, the one not served last wins; with a single
    // pending sensor that one wins (pend[1] alone -> 1, pend[0] alone -> 0).
    function automatic logic pick_winner(input logic [1:0] pend, input logic last_served);
        return (&pend) ? ~last_served : pend[1];
    endfunction

endpackage

// File: rtl/bno08x_dual_sensor_scheduler_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (resets to RESET_VAL)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VAL;
            q_reg    <= RESET_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/bno08x_dual_sensor_scheduler.sv
// Time-multiplexes one shared BNO08X SPI controller / drum datapath between
// two sensors with round-robin fairness.
//   clk, rst_n             : 3 MHz clock, asynchronous active-low reset
//   enable                 : allow new grants
//   h_intn1, h_intn2       : raw active-low sensor interrupts (async)
//   spi_cs_n_in            : chip select from the shared controller
//   ctrl_busy, txn_done    : controller status / report-done pulse
//   trig_in, trig_valid_in : drum code from the shared processor
//   sensor_select          : 0 = sensor 1, 1 = sensor 2
//   h_intn_mux             : interrupt forwarded to the controller
//   cs1_n, cs2_n           : gated per-sensor chip selects
//   trig1/2, trig_valid1/2 : per-sensor drum code and pulse
//   timeout_err            : sticky per-sensor timeout flags
module bno08x_dual_sensor_scheduler
    import bno08x_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       h_intn1,
    input  logic       h_intn2,
    input  logic       spi_cs_n_in,
    input  logic       ctrl_busy,
    input  logic       txn_done,
    input  logic [3:0] trig_in,
    input  logic       trig_valid_in,
    output logic       sensor_select,
    output logic       h_intn_mux,
    output logic       cs1_n,
    output logic       cs2_n,
    output logic [3:0] trig1,
    output logic [3:0] trig2,
    output logic       trig_valid1,
    output logic       trig_valid2,
    output logic [1:0] timeout_err
);

    localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0] intn_raw;
    logic [1:0] intn_sync;
    logic [1:0] pend;

    assign intn_raw = {h_intn2, h_intn1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            sync_2ff #(.RESET_VAL(1'b1)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (intn_raw[gi]),
                .q     (intn_sync[gi])
            );
        end
    endgenerate

    assign pend = ~intn_sync;

    sched_state_t         state_reg, state_next;
    logic                 sel_reg, sel_next;
    logic                 last_reg, last_next;
    logic [SETTLE_W-1:0]  settle_cnt_reg, settle_cnt_next;
    logic [TIMEOUT_W-1:0] to_cnt_reg, to_cnt_next;
    logic [1:0]           terr_reg, terr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= 1'b0;
            last_reg       <= 1'b1;   // sensor 1 wins the first tie
            settle_cnt_reg <= '0;
            to_cnt_reg     <= '0;
            terr_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            last_reg       <= last_next;
            settle_cnt_reg <= settle_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            terr_reg       <= terr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        last_next       = last_reg;
        settle_cnt_next = settle_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        terr_next       = terr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable && !ctrl_busy && (|pend)) begin
                    sel_next        = pick_winner(pend, last_reg);
                    settle_cnt_next = '0;
                    state_next      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Counter starts at 0, so SETTLE lasts SETTLE_CYCLES+1 cycles.
                if (settle_cnt_reg == SETTLE_LAST) begin
                    to_cnt_next = '0;
                    state_next  = ST_ACTIVE;
                end else begin
                    settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
                end
            end
            ST_ACTIVE: begin
                // txn_done is checked first so it beats a coincident timeout.
                if (txn_done) begin
                    state_next = ST_RELEASE;
                end else if (to_cnt_reg == TIMEOUT_LAST) begin
                    terr_next[sel_reg] = 1'b1;
                    state_next         = ST_RELEASE;
                end else begin
                    to_cnt_next = to_cnt_reg + TIMEOUT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!ctrl_busy) begin
                    last_next  = sel_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Grant is held in ACTIVE and RELEASE so the controller can finish its
    // current SPI frame after txn_done.
    logic granted;
    logic trig_accept;
    assign granted     = (state_reg == ST_ACTIVE) || (state_reg == ST_RELEASE);
    assign trig_accept = trig_valid_in && granted;

    logic [1:0][3:0] trig_reg;
    logic [1:0]      tv_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_reg <= {2{DRUM_NONE}};
            tv_reg   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                tv_reg[i] <= trig_accept && (sel_reg == 1'(i));
                if (trig_accept && (sel_reg == 1'(i))) begin
                    trig_reg[i] <= trig_in;
                end
            end
        end
    end

    assign sensor_select = sel_reg;
    assign h_intn_mux    = (state_reg == ST_ACTIVE) ? intn_sync[sel_reg] : 1'b1;
    assign cs1_n         = (granted && !sel_reg) ? spi_cs_n_in : 1'b1;
    assign cs2_n         = (granted &&  sel_reg) ? spi_cs_n_in : 1'b1;
    assign trig1         = trig_reg[0];
    assign trig2         = trig_reg[1];
    assign trig_valid1   = tv_reg[0];
    assign trig_valid2   = tv_reg[1];
    assign timeout_err   = terr_reg;

endmodule

// File: tb/tb_bno08x_dual_sensor_scheduler.sv
module tb_bno08x_dual_sensor_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       h_intn1, h_intn2;
    logic       spi_cs_n_in;
    logic       ctrl_busy;
    logic       txn_done;
    logic [3:0] trig_in;
    logic       trig_valid_in;
    logic       sensor_select;
    logic       h_intn_mux;
    logic       cs1_n, cs2_n;
    logic [3:0] trig1, trig2;
    logic       trig_valid1, trig_valid2;
    logic [1:0] timeout_err;

    int total = 0;
    int bad   = 0;

    bno08x_dual_sensor_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .h_intn1       (h_intn1),
        .h_intn2       (h_intn2),
        .spi_cs_n_in   (spi_cs_n_in),
        .ctrl_busy     (ctrl_busy),
        .txn_done      (txn_done),
        .trig_in       (trig_in),
        .trig_valid_in (trig_valid_in),
        .sensor_select (sensor_select),
        .h_intn_mux    (h_intn_mux),
        .cs1_n         (cs1_n),
        .cs2_n         (cs2_n),
        .trig1         (trig1),
        .trig2         (trig2),
        .trig_valid1   (trig_valid1),
        .trig_valid2   (trig_valid2),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         lo1;
        bit         lo2;
        logic [3:0] code;
        bit         exp_sel;
        logic [3:0] e1;
        logic [3:0] e2;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_active(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (h_intn_mux == 1'b0) seen = 1'b1;
        end
    endtask

    // One complete grant: raise interrupts, wait for ACTIVE, check selection
    // and CS gating, push a trigger, finish with txn_done (optionally holding
    // ctrl_busy in RELEASE and pushing a second trigger there).
    task automatic do_grant(input string tag, input bit lo1, input bit lo2,
                            input logic [3:0] code, input logic [3:0] code2,
                            input bit exp_sel, input logic [3:0] e1,
                            input logic [3:0] e2, input int hold);
        bit seen;
        h_intn1 = !lo1;
        h_intn2 = !lo2;
        spi_cs_n_in = 1'b1;
        wait_active(seen);
        chk({tag, ".grant"}, 32'(seen), 32'd1);
        chk({tag, ".sel"}, 32'(sensor_select), 32'(exp_sel));
        spi_cs_n_in = 1'b0;
        #1;
        chk({tag, ".cs_sel"}, 32'(exp_sel ? cs2_n : cs1_n), 32'd0);
        chk({tag, ".cs_oth"}, 32'(exp_sel ? cs1_n : cs2_n), 32'd1);
        trig_in = code;
        trig_valid_in = 1'b1;
        tick();
        trig_valid_in = 1'b0;
        chk({tag, ".tv_sel"}, 32'(exp_sel ? trig_valid2 : trig_valid1), 32'd1);
        chk({tag, ".tv_oth"}, 32'(exp_sel ? trig_valid1 : trig_valid2), 32'd0);
        chk({tag, ".trig_sel"}, 32'(exp_sel ? trig2 : trig1), 32'(code));
        tick();
        chk({tag, ".tv_clr"}, 32'({trig_valid1, trig_valid2}), 32'd0);
        h_intn1 = 1'b1;
        h_intn2 = 1'b1;
        ctrl_busy = (hold > 0);
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        for (int k = 0; k < hold; k++) begin
            chk({tag, ".rel_cs"}, 32'(exp_sel ? cs2_n : cs1_n), 32'd0);
            if (k == 0) begin
                trig_in = code2;
                trig_valid_in = 1'b1;
                tick();
                trig_valid_in = 1'b0;
                chk({tag, ".rel_tv"}, 32'(exp_sel ? trig_valid2 : trig_valid1), 32'd1);
                chk({tag, ".rel_trig"}, 32'(exp_sel ? trig2 : trig1), 32'(code2));
            end else begin
                tick();
            end
        end
        ctrl_busy = 1'b0;
        tick();
        chk({tag, ".idle_cs"}, 32'({cs1_n, cs2_n}), 32'b11);
        chk({tag, ".trig1"}, 32'(trig1), 32'(e1));
        chk({tag, ".trig2"}, 32'(trig2), 32'(e2));
        spi_cs_n_in = 1'b1;
        repeat (2) tick();
        $display("txn %s: sel=%0d trig1=%0d trig2=%0d", tag, sensor_select, trig1, trig2);
    endtask

    initial begin
        bit         seen;
        bit         last_m;
        logic [3:0] m_trig [2];
        int         cnt;

        tbl[0] = '{1'b1, 1'b1, 4'd5,  1'b0, 4'd5, 4'd8};
        tbl[1] = '{1'b1, 1'b1, 4'd3,  1'b1, 4'd5, 4'd3};
        tbl[2] = '{1'b1, 1'b1, 4'd0,  1'b0, 4'd0, 4'd3};
        tbl[3] = '{1'b1, 1'b1, 4'd15, 1'b1, 4'd0, 4'd15};
        tbl[4] = '{1'b0, 1'b1, 4'd7,  1'b1, 4'd0, 4'd7};
        tbl[5] = '{1'b0, 1'b1, 4'd9,  1'b1, 4'd0, 4'd9};
        tbl[6] = '{1'b1, 1'b0, 4'd2,  1'b0, 4'd2, 4'd9};
        tbl[7] = '{1'b1, 1'b1, 4'd11, 1'b1, 4'd2, 4'd11};

        rst_n = 1'b0;
        enable = 1'b1;
        h_intn1 = 1'b1;
        h_intn2 = 1'b1;
        spi_cs_n_in = 1'b1;
        ctrl_busy = 1'b0;
        txn_done = 1'b0;
        trig_in = 4'd0;
        trig_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.sel", 32'(sensor_select), 32'd0);
        chk("rst.mux", 32'(h_intn_mux), 32'd1);
        chk("rst.cs", 32'({cs1_n, cs2_n}), 32'b11);
        chk("rst.trig1", 32'(trig1), 32'd8);
        chk("rst.trig2", 32'(trig2), 32'd8);
        chk("rst.tv", 32'({trig_valid1, trig_valid2}), 32'd0);
        chk("rst.terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table: round-robin alternation, single-pending grants, trigger steering.
        for (int i = 0; i < 8; i++) begin
            do_grant($sformatf("vec%0d", i), tbl[i].lo1, tbl[i].lo2, tbl[i].code, 4'd0,
                     tbl[i].exp_sel, tbl[i].e1, tbl[i].e2, 0);
        end

        // Interrupt-to-forward latency: 7 edges from the fall.
        h_intn1 = 1'b0;
        repeat (6) tick();
        chk("lat.mux_at6", 32'(h_intn_mux), 32'd1);
        tick();
        chk("lat.mux_at7", 32'(h_intn_mux), 32'd0);
        chk("lat.sel", 32'(sensor_select), 32'd0);
        spi_cs_n_in = 1'b0;
        #1;
        chk("lat.cs", 32'({cs1_n, cs2_n}), 32'b01);
        ctrl_busy = 1'b1;
        txn_done = 1'b1;
        h_intn1 = 1'b1;
        tick();
        txn_done = 1'b0;
        chk("lat.rel_cs1", 32'(cs1_n), 32'd0);
        tick();
        chk("lat.rel_hold", 32'(cs1_n), 32'd0);
        ctrl_busy = 1'b0;
        tick();
        chk("lat.idle_cs", 32'({cs1_n, cs2_n}), 32'b11);
        $display("txn latency: sel=%0d", sensor_select);
        spi_cs_n_in = 1'b1;
        repeat (2) tick();

        // Randomized grants against a round-robin model.
        last_m = 1'b0;
        m_trig[0] = tbl[7].e1;
        m_trig[1] = tbl[7].e2;
        for (int r = 0; r < 24; r++) begin
            int         pat;
            int         hold;
            bit         esel;
            logic [3:0] c1, c2;
            pat  = $urandom_range(1, 3);
            hold = $urandom_range(0, 2);
            c1   = 4'($urandom_range(0, 15));
            c2   = 4'($urandom_range(0, 15));
            esel = (pat == 3) ? !last_m : (pat == 2);
            if ($urandom_range(0, 1) == 1) begin
                trig_in = 4'($urandom_range(0, 15));
                trig_valid_in = 1'b1;
                tick();
                trig_valid_in = 1'b0;
                chk("rnd.idle_tv", 32'({trig_valid1, trig_valid2}), 32'd0);
                tick();
                chk("rnd.idle_trig", 32'({trig1, trig2}), 32'({m_trig[0], m_trig[1]}));
            end
            m_trig[esel] = (hold > 0) ? c2 : c1;
            last_m = esel;
            do_grant($sformatf("rnd%0d", r), pat[0], pat[1], c1, c2, esel,
                     m_trig[0], m_trig[1], hold);
        end

        // Timeout on sensor 2.
        h_intn2 = 1'b0;
        wait_active(seen);
        chk("to.grant", 32'(seen), 32'd1);
        chk("to.sel", 32'(sensor_select), 32'd1);
        h_intn2 = 1'b1;
        repeat (29999) tick();
        chk("to.before", 32'(timeout_err), 32'd0);
        tick();
        chk("to.after", 32'(timeout_err), 32'b10);
        $display("txn timeout: terr=%b", timeout_err);
        tick();
        h_intn1 = 1'b0;
        wait_active(seen);
        chk("to.next_grant", 32'(seen), 32'd1);
        chk("to.next_sel", 32'(sensor_select), 32'd0);
        // txn_done on the very cycle the timeout would fire: no error.
        h_intn1 = 1'b1;
        repeat (29999) tick();
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        chk("to.done_wins", 32'(timeout_err), 32'b10);
        tick();
        $display("txn boundary: terr=%b", timeout_err);
        repeat (2) tick();

        // Asynchronous reset during ACTIVE.
        h_intn2 = 1'b0;
        wait_active(seen);
        chk("ar.grant", 32'(seen), 32'd1);
        spi_cs_n_in = 1'b0;
        #1;
        chk("ar.cs2_pre", 32'(cs2_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.cs", 32'({cs1_n, cs2_n}), 32'b11);
        chk("ar.mux", 32'(h_intn_mux), 32'd1);
        chk("ar.sel", 32'(sensor_select), 32'd0);
        chk("ar.terr", 32'(timeout_err), 32'd0);
        $display("txn async_reset: cs=%b%b sel=%0d", cs1_n, cs2_n, sensor_select);
        h_intn2 = 1'b1;
        spi_cs_n_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Enable dropped mid-grant with both interrupts held low.
        h_intn1 = 1'b0;
        h_intn2 = 1'b0;
        wait_active(seen);
        chk("en.grant", 32'(seen), 32'd1);
        chk("en.sel", 32'(sensor_select), 32'd0);
        enable = 1'b0;
        spi_cs_n_in = 1'b0;
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        tick();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (h_intn_mux == 1'b0 || cs1_n == 1'b0 || cs2_n == 1'b0) cnt++;
        end
        chk("en.no_grant", 32'(cnt), 32'd0);
        enable = 1'b1;
        wait_active(seen);
        chk("en.regrant", 32'(seen), 32'd1);
        chk("en.resel", 32'(sensor_select), 32'd1);
        $display("txn enable: sel=%0d", sensor_select);
        h_intn1 = 1'b1;
        h_intn2 = 1'b1;
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
